// File: rtl/anthem_pkg.sv
// Shared definitions for the anthem phrase checker: phrase ROM contents, FSM states, case fold.
// ANTHEM_CASE_FOLD_EN (in the top) makes compares case-insensitive.
package anthem_pkg;

  localparam int PHRASE_LEN = 36;

  // Character 0 sits in the most significant byte of the literal.
  localparam logic [PHRASE_LEN*8-1:0] PHRASE = "Tajumulco Tacana Acatenango Fuego Sa";

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  function automatic logic [7:0] case_fold(input logic [7:0] b);
    if (b >= 8'h41 && b <= 8'h5A) begin
      return b + 8'h20;
    end
    return b;
  endfunction

endpackage

// File: rtl/anthem_phrase_rom.sv
// Combinational phrase lookup: idx -> expected byte; out-of-range indices read 0x00.
module anthem_phrase_rom
  import anthem_pkg::*;
(
  input  logic [5:0] idx,
  output logic [7:0] rom_byte
);

  always_comb begin
    rom_byte = 8'h00;
    for (int i = 0; i < PHRASE_LEN; i++) begin
      if (idx == 6'(i)) begin
        rom_byte = PHRASE[(PHRASE_LEN-1-i)*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/anthem_stream_checker.sv
// Receive-side anthem phrase checker: hunts for phrase start, tracks position, counts errors, locks.
// All outputs registered one cycle after the accepted byte; macro ANTHEM_CASE_FOLD_EN enables case-insensitive compare.
module anthem_stream_checker
  import anthem_pkg::*;
#(
  parameter int LOCK_PHRASES = 2,
  parameter int ERR_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             clear,
  output logic             locked,
  output logic             phrase_done,
  output logic             mismatch,
  output logic [5:0]       index_out,
  output logic [ERR_W-1:0] err_count
);

  localparam int          GOOD_W     = $clog2(LOCK_PHRASES + 1);
  localparam logic [5:0]  LAST_IDX   = 6'(PHRASE_LEN - 1);
  localparam logic [7:0]  FIRST_BYTE = PHRASE[PHRASE_LEN*8-1 -: 8];

  function automatic logic byte_eq(input logic [7:0] a, input logic [7:0] b);
`ifdef ANTHEM_CASE_FOLD_EN
    return case_fold(a) == case_fold(b);
`else
    return a == b;
`endif
  endfunction

  state_t             state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               locked_q, locked_d;
  logic               done_q, done_d;
  logic               mis_q, mis_d;
  logic [7:0]         exp_byte;

  anthem_phrase_rom u_rom (
    .idx      (idx_q),
    .rom_byte (exp_byte)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    good_d   = good_q;
    err_d    = err_q;
    locked_d = locked_q;
    done_d   = 1'b0;
    mis_d    = 1'b0;

    if (ena && clear) begin
      state_d  = HUNT;
      idx_d    = 6'd0;
      good_d   = '0;
      err_d    = '0;
      locked_d = 1'b0;
    end else if (ena && byte_valid) begin
      if (state_q == HUNT) begin
        if (byte_eq(byte_in, FIRST_BYTE)) begin
          state_d = TRACK;
          idx_d   = 6'd1;
        end
      end else if (byte_eq(byte_in, exp_byte)) begin
        if (idx_q == LAST_IDX) begin
          idx_d  = 6'd0;
          done_d = 1'b1;
          if (good_q != GOOD_W'(LOCK_PHRASES)) begin
            good_d = good_q + 1'b1;
          end
          locked_d = (good_d == GOOD_W'(LOCK_PHRASES));
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end else begin
        // A bad byte that is itself a phrase start re-arms tracking immediately.
        mis_d    = 1'b1;
        good_d   = '0;
        locked_d = 1'b0;
        if (err_q != '1) begin
          err_d = err_q + 1'b1;
        end
        if (byte_eq(byte_in, FIRST_BYTE)) begin
          idx_d = 6'd1;
        end else begin
          state_d = HUNT;
          idx_d   = 6'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      idx_q    <= 6'd0;
      good_q   <= '0;
      err_q    <= '0;
      locked_q <= 1'b0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      good_q   <= good_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      done_q   <= done_d;
      mis_q    <= mis_d;
    end
  end

  assign locked      = locked_q;
  assign phrase_done = done_q;
  assign mismatch    = mis_q;
  assign index_out   = idx_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_anthem_stream_checker.sv
// Bench for anthem_stream_checker: directed scenarios plus randomized stream against a phrase-level model.
// Build with ANTHEM_CASE_FOLD_EN defined to exercise the case-insensitive variant.
module tb_anthem_stream_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       clear = 1'b0;
  logic       locked;
  logic       phrase_done;
  logic       mismatch;
  logic [5:0] index_out;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_fail = 0;

  string ph = "Tajumulco Tacana Acatenango Fuego Sa";

  // Reference model: position within the text, tracking flag, plain integer counters.
  bit m_track;
  int m_pos, m_good, m_err;
  bit m_locked, m_done, m_mis;

  anthem_stream_checker #(.LOCK_PHRASES(2), .ERR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .clear       (clear),
    .locked      (locked),
    .phrase_done (phrase_done),
    .mismatch    (mismatch),
    .index_out   (index_out),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pch(input int i);
    return ph[i % 36];
  endfunction

  function automatic logic [7:0] upper(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
  endfunction

  function automatic bit same(input logic [7:0] a, input logic [7:0] b);
`ifdef ANTHEM_CASE_FOLD_EN
    return upper(a) == upper(b);
`else
    return a == b;
`endif
  endfunction

  task automatic model_reset();
    m_track = 0; m_pos = 0; m_good = 0; m_err = 0;
    m_locked = 0; m_done = 0; m_mis = 0;
  endtask

  task automatic model_step(input logic [7:0] b, input bit v, input bit e, input bit c);
    m_done = 0;
    m_mis  = 0;
    if (!e) return;
    if (c) begin
      model_reset();
      return;
    end
    if (!v) return;
    if (!m_track) begin
      if (same(b, pch(0))) begin m_track = 1; m_pos = 1; end
    end else if (same(b, pch(m_pos))) begin
      if (m_pos == 35) begin
        m_pos = 0; m_done = 1;
        if (m_good < 2) m_good++;
        m_locked = (m_good >= 2);
      end else begin
        m_pos++;
      end
    end else begin
      m_mis = 1; m_good = 0; m_locked = 0;
      if (m_err < 255) m_err++;
      if (same(b, pch(0))) m_pos = 1;
      else begin m_track = 0; m_pos = 0; end
    end
  endtask

  // Drive one cycle; outputs are sampled 1 time unit after the capturing edge.
  task automatic cycle(input logic [7:0] b, input bit v, input bit e, input bit c);
    byte_in = b; byte_valid = v; ena = e; clear = c;
    @(posedge clk);
    model_step(b, v, e, c);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({locked, phrase_done, mismatch, index_out, err_count} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b/%b/%b/%0d/%0d want all zero",
               locked, phrase_done, mismatch, index_out, err_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_two_phrases();
    for (int i = 0; i < 72; i++) begin
      cycle(pch(i), 1, 1, 0);
      n_cmp++;
      if (phrase_done !== ((i == 35) || (i == 71)) || mismatch !== 1'b0) begin
        n_fail++;
        $display("FAIL two_phrases_pulse[%0d]: done=%b mis=%b want done=%b mis=0",
                 i, phrase_done, mismatch, (i == 35) || (i == 71));
      end
      if (i == 35) begin
        n_cmp++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %b want 0", locked); end
      end
    end
    n_cmp++;
    if (locked !== 1'b1 || err_count !== 8'd0 || index_out !== 6'd0) begin
      n_fail++;
      $display("FAIL lock_after_two: locked=%b err=%0d idx=%0d want 1/0/0", locked, err_count, index_out);
    end
  endtask

  task automatic test_mismatch_locked();
    for (int i = 0; i < 12; i++) cycle(pch(i), 1, 1, 0);
    cycle(8'h64, 1, 1, 0);
    n_cmp++;
    if (mismatch !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || index_out !== 6'd0) begin
      n_fail++;
      $display("FAIL bad_byte12: mis=%b err=%0d locked=%b idx=%0d want 1/1/0/0",
               mismatch, err_count, locked, index_out);
    end
    cycle(8'h00, 0, 1, 0);
    n_cmp++;
    if (mismatch !== 1'b0) begin n_fail++; $display("FAIL mis_one_cycle: got %b want 0", mismatch); end
    for (int i = 0; i < 36; i++) cycle(pch(i), 1, 1, 0);
    n_cmp++;
    if (phrase_done !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL recover_phrase: done=%b err=%0d locked=%b want 1/1/0", phrase_done, err_count, locked);
    end
  endtask

  task automatic test_restart_on_t();
    for (int i = 0; i < 5; i++) cycle(pch(i), 1, 1, 0);
    cycle(8'h54, 1, 1, 0);
    n_cmp++;
    if (mismatch !== 1'b1 || index_out !== 6'd1 || err_count !== 8'd2) begin
      n_fail++;
      $display("FAIL restart_t: mis=%b idx=%0d err=%0d want 1/1/2", mismatch, index_out, err_count);
    end
    for (int i = 1; i < 36; i++) cycle(pch(i), 1, 1, 0);
    n_cmp++;
    if (phrase_done !== 1'b1 || mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_complete: done=%b mis=%b want 1/0", phrase_done, mismatch);
    end
  endtask

  task automatic test_ena_hold();
    for (int i = 0; i < 20; i++) cycle(pch(i), 1, 1, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(8'($urandom), 1, 0, k == 2);
      n_cmp++;
      if (phrase_done !== 1'b0 || mismatch !== 1'b0 || index_out !== 6'd20 || err_count !== 8'd2) begin
        n_fail++;
        $display("FAIL ena_low[%0d]: done=%b mis=%b idx=%0d err=%0d want 0/0/20/2",
                 k, phrase_done, mismatch, index_out, err_count);
      end
    end
    for (int i = 20; i < 36; i++) cycle(pch(i), 1, 1, 0);
    n_cmp++;
    if (phrase_done !== 1'b1 || err_count !== 8'd2) begin
      n_fail++;
      $display("FAIL ena_resume: done=%b err=%0d want 1/2", phrase_done, err_count);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 7; i++) cycle(pch(i), 1, 1, 0);
    n_cmp++;
    if (index_out !== 6'd7) begin n_fail++; $display("FAIL pre_clear_idx: got %0d want 7", index_out); end
    cycle(pch(7), 1, 1, 1);
    n_cmp++;
    if (err_count !== 8'd0 || index_out !== 6'd0 || locked !== 1'b0 || mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL clear: err=%0d idx=%0d locked=%b mis=%b want 0/0/0/0",
               err_count, index_out, locked, mismatch);
    end
    cycle(pch(7), 1, 1, 0);
    n_cmp++;
    if (index_out !== 6'd0 || mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL post_clear_hunt: idx=%0d mis=%b want 0/0", index_out, mismatch);
    end
  endtask

  task automatic test_saturate_and_case();
    cycle(8'h54, 1, 1, 0);
    for (int k = 0; k < 300; k++) cycle(8'h54, 1, 1, 0);
    n_cmp++;
    if (err_count !== 8'hFF || mismatch !== 1'b1) begin
      n_fail++;
      $display("FAIL err_saturate: err=%0h mis=%b want ff/1", err_count, mismatch);
    end
    cycle(8'h00, 0, 1, 1);
    cycle(8'h74, 1, 1, 0);
`ifdef ANTHEM_CASE_FOLD_EN
    n_cmp++;
    if (index_out !== 6'd1) begin n_fail++; $display("FAIL fold_lower_t: idx=%0d want 1", index_out); end
    cycle(8'h00, 1, 1, 0);
    for (int i = 0; i < 36; i++) begin
      cycle(upper(pch(i)), 1, 1, 0);
      n_cmp++;
      if (mismatch !== 1'b0 || phrase_done !== (i == 35)) begin
        n_fail++;
        $display("FAIL fold_upper[%0d]: mis=%b done=%b want 0/%b", i, mismatch, phrase_done, i == 35);
      end
    end
`else
    n_cmp++;
    if (index_out !== 6'd0 || mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL exact_lower_t: idx=%0d mis=%b want 0/0", index_out, mismatch);
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    for (int i = 0; i < 10; i++) cycle(pch(i), 1, 1, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (index_out !== 6'd0 || phrase_done !== 1'b0 || mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_phrase: idx=%0d done=%b mis=%b want 0/0/0", index_out, phrase_done, mismatch);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      b = pch(m_track ? m_pos : 0);
      if (r < 6) b = 8'($urandom);
      else if (r < 9) b = 8'h54;
      else if (r < 12) b = upper(b);
      cycle(b, $urandom_range(0, 9) != 0, $urandom_range(0, 19) != 0, $urandom_range(0, 199) == 0);
      n_cmp++;
      if (locked !== m_locked || phrase_done !== m_done || mismatch !== m_mis ||
          index_out !== 6'(m_pos) || err_count !== 8'(m_err)) begin
        n_fail++;
        $display("FAIL random[%0d]: got l=%b d=%b m=%b i=%0d e=%0d want l=%b d=%b m=%b i=%0d e=%0d",
                 n, locked, phrase_done, mismatch, index_out, err_count,
                 m_locked, m_done, m_mis, m_pos, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_phrases();
    test_mismatch_locked();
    test_restart_on_t();
    test_ena_hold();
    test_clear();
    test_saturate_and_case();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
